// File: rtl/fsm_pkg.sv
// fsm_pkg: shared mode codes, one-hot state indices and state type for fsm_seq (FSM_SEQ_ILLEGAL_TRAP_EN adds SJAM)
package fsm_pkg;
  localparam logic [2:0] MODE_IMP = 3'd0;
  localparam logic [2:0] MODE_IMM = 3'd1;
  localparam logic [2:0] MODE_ZP  = 3'd2;
  localparam logic [2:0] MODE_ZPI = 3'd3;
  localparam logic [2:0] MODE_ABS = 3'd4;
  localparam logic [2:0] MODE_ABI = 3'd5;
  localparam logic [2:0] MODE_IDY = 3'd6;
  localparam logic [2:0] MODE_ILL = 3'd7;
  localparam int ST_S0  = 0;
  localparam int ST_SOP = 1;
  localparam int ST_SLO = 2;
  localparam int ST_SHI = 3;
  localparam int ST_SIN = 4;
  localparam int ST_SCO = 5;
  localparam int ST_SLR = 6;
  localparam int ST_JAM = 7;
`ifdef FSM_SEQ_ILLEGAL_TRAP_EN
  localparam int STATE_W = 8;
`else
  localparam int STATE_W = 7;
`endif
  typedef enum logic [STATE_W-1:0] {
    S_S0  = STATE_W'(1) << ST_S0,
    S_SOP = STATE_W'(1) << ST_SOP,
    S_SLO = STATE_W'(1) << ST_SLO,
    S_SHI = STATE_W'(1) << ST_SHI,
    S_SIN = STATE_W'(1) << ST_SIN,
    S_SCO = STATE_W'(1) << ST_SCO,
`ifdef FSM_SEQ_ILLEGAL_TRAP_EN
    S_JAM = STATE_W'(1) << ST_JAM,
`endif
    S_SLR = STATE_W'(1) << ST_SLR
  } state_t;
endpackage

// File: rtl/fsm_seq.sv
// fsm_seq: one-hot 6502 micro-sequencer; CLK/RST_N(sync low)/RDY/MODE/ST/CO in, strobes S0..SLR + CYC (+JAM with FSM_SEQ_ILLEGAL_TRAP_EN) out
module fsm_seq
  import fsm_pkg::*;
#(
  parameter int CYC_W = 3
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             RDY,
  input  logic [2:0]       MODE,
  input  logic             ST,
  input  logic             CO,
  output logic             S0,
  output logic             SLO,
  output logic             SHI,
  output logic             SIN,
  output logic             SCO,
  output logic             SLR,
  output logic             SOP,
  output logic [CYC_W-1:0] CYC
`ifdef FSM_SEQ_ILLEGAL_TRAP_EN
  , output logic           JAM
`endif
);
  state_t r_state;
  logic [2:0] r_mode;
  logic r_st;
  logic [CYC_W-1:0] r_cyc;
  state_t w_adv, w_next, w_r;
  logic w_cx, w_legal;
  always_comb begin
    w_r = r_st ? S_SOP : S_SLR;
    w_cx = (r_mode == MODE_ABI || r_mode == MODE_IDY) && CO;
    w_legal = 1'b1;
    w_adv = S_S0;
    case (r_state)
      S_S0: begin
        w_adv = (MODE == MODE_IMP || MODE == MODE_IMM || MODE == MODE_ILL) ? S_SOP : S_SLO;
`ifdef FSM_SEQ_ILLEGAL_TRAP_EN
        if (MODE == MODE_ILL) w_adv = S_JAM;
`endif
      end
      S_SLO: w_adv = (r_mode == MODE_ZP) ? w_r :
                     (r_mode == MODE_ZPI || r_mode == MODE_IDY) ? S_SIN :
                     (r_mode == MODE_ABS || r_mode == MODE_ABI) ? S_SHI : S_SOP;
      S_SIN: w_adv = (r_mode == MODE_IDY) ? S_SHI : w_r;
      S_SHI: w_adv = w_cx ? S_SCO : w_r;
      S_SCO: w_adv = w_r;
      S_SLR: w_adv = S_SOP;
      S_SOP: w_adv = S_S0;
`ifdef FSM_SEQ_ILLEGAL_TRAP_EN
      S_JAM: w_adv = S_JAM;
`endif
      default: w_legal = 1'b0;
    endcase
    // a corrupted one-hot pattern recovers even while RDY is low
    w_next = (RDY || !w_legal) ? w_adv : r_state;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_S0;
      r_mode <= '0;
      r_st <= 1'b0;
      r_cyc <= '0;
    end else begin
      r_state <= w_next;
      if (RDY && r_state == S_S0) begin
        r_mode <= MODE;
        r_st <= ST;
      end
      // only self-looping state is SJAM, so a state change marks an advance
      r_cyc <= (w_next == S_S0) ? '0 : (w_next != r_state && !(&r_cyc)) ? r_cyc + 1'b1 : r_cyc;
    end
  end
  assign S0  = r_state[ST_S0];
  assign SOP = r_state[ST_SOP];
  assign SLO = r_state[ST_SLO];
  assign SHI = r_state[ST_SHI];
  assign SIN = r_state[ST_SIN];
  assign SCO = r_state[ST_SCO];
  assign SLR = r_state[ST_SLR];
  assign CYC = r_cyc;
`ifdef FSM_SEQ_ILLEGAL_TRAP_EN
  assign JAM = r_state[ST_JAM];
`endif
endmodule

// File: tb/tb_fsm_seq.sv
// tb_fsm_seq: scoreboard bench for fsm_seq with directed vectors
module tb_fsm_seq;
  localparam logic [6:0] XS0  = 7'b1000000;
  localparam logic [6:0] XSOP = 7'b0100000;
  localparam logic [6:0] XSLO = 7'b0010000;
  localparam logic [6:0] XSHI = 7'b0001000;
  localparam logic [6:0] XSIN = 7'b0000100;
  localparam logic [6:0] XSCO = 7'b0000010;
  localparam logic [6:0] XSLR = 7'b0000001;
  localparam logic [6:0] XNON = 7'b0000000;
  typedef struct packed {
    logic [6:0] s;
    logic jam;
    logic [2:0] cyc;
    logic chk_cyc;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n, rdy, st, co;
  logic [2:0] mode;
  logic s0, slo, shi, sin, sco, slr, sop;
  logic [2:0] cyc;
  logic jam;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  fsm_seq #(.CYC_W(3)) dut (
    .CLK(clk), .RST_N(rst_n), .RDY(rdy), .MODE(mode), .ST(st), .CO(co),
    .S0(s0), .SLO(slo), .SHI(shi), .SIN(sin), .SCO(sco), .SLR(slr), .SOP(sop),
    .CYC(cyc)
`ifdef FSM_SEQ_ILLEGAL_TRAP_EN
    , .JAM(jam)
`endif
  );
`ifndef FSM_SEQ_ILLEGAL_TRAP_EN
  assign jam = 1'b0;
`endif
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [6:0] act;
      e = q.pop_front();
      act = {s0, sop, slo, shi, sin, sco, slr};
      checks++;
      if (act !== e.s || jam !== e.jam || (e.chk_cyc && cyc !== e.cyc)) begin
        errors++;
        $display("FAIL step @%0t: strobes=%b jam=%b cyc=%0d expected strobes=%b jam=%b cyc=%0d",
                 $time, act, jam, cyc, e.s, e.jam, e.cyc);
      end
    end
  end
  task automatic step(input logic rn, input logic rd, input logic [2:0] m, input logic s,
                      input logic c, input logic [6:0] xs, input logic [2:0] xc);
    rst_n = rn; rdy = rd; mode = m; st = s; co = c;
    q.push_back('{s: xs, jam: 1'b0, cyc: xc, chk_cyc: 1'b1});
    @(posedge clk); #1;
  endtask
  task automatic stepj(input logic rn, input logic rd);
    rst_n = rn; rdy = rd; mode = 3'($urandom_range(0, 7)); st = 1'($urandom); co = 1'($urandom);
    q.push_back('{s: XNON, jam: 1'b1, cyc: 3'd0, chk_cyc: 1'b0});
    @(posedge clk); #1;
  endtask
  initial begin
    rst_n = 1'b0; rdy = 1'($urandom); mode = 3'($urandom); st = 1'($urandom); co = 1'($urandom);
    @(posedge clk); #1;
    step(0, 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), XS0, 0);
    // IMM
    step(1, 1, 1, 0, 0, XS0, 0);
    step(1, 1, 0, 0, 0, XSOP, 1);
    // ABS load, CO high must be ignored outside ABI/IDY
    step(1, 1, 4, 0, 1, XS0, 0);
    step(1, 1, 0, 1, 1, XSLO, 1);
    step(1, 1, 0, 1, 1, XSHI, 2);
    step(1, 1, 0, 1, 1, XSLR, 3);
    step(1, 1, 0, 1, 1, XSOP, 4);
    // ABI page cross
    step(1, 1, 5, 0, 0, XS0, 0);
    step(1, 1, 0, 0, 0, XSLO, 1);
    step(1, 1, 0, 0, 1, XSHI, 2);
    step(1, 1, 0, 0, 0, XSCO, 3);
    step(1, 1, 0, 0, 0, XSLR, 4);
    step(1, 1, 0, 0, 0, XSOP, 5);
    // ABI no cross
    step(1, 1, 5, 0, 0, XS0, 0);
    step(1, 1, 0, 0, 1, XSLO, 1);
    step(1, 1, 0, 0, 0, XSHI, 2);
    step(1, 1, 0, 0, 1, XSLR, 3);
    step(1, 1, 0, 0, 0, XSOP, 4);
    // IDY store, CO=1, SIN stretched by RDY=0
    step(1, 1, 6, 1, 0, XS0, 0);
    step(1, 1, 0, 0, 0, XSLO, 1);
    step(1, 0, 0, 0, 1, XSIN, 2);
    step(1, 0, 0, 0, 1, XSIN, 2);
    step(1, 0, 0, 0, 1, XSIN, 2);
    step(1, 1, 0, 0, 0, XSIN, 2);
    step(1, 1, 0, 0, 1, XSHI, 3);
    step(1, 1, 0, 0, 0, XSCO, 4);
    step(1, 1, 0, 0, 0, XSOP, 5);
    // IDY load, CO=1: longest sequence
    step(1, 1, 6, 0, 0, XS0, 0);
    step(1, 1, 0, 1, 0, XSLO, 1);
    step(1, 1, 0, 1, 0, XSIN, 2);
    step(1, 1, 0, 1, 1, XSHI, 3);
    step(1, 1, 0, 1, 0, XSCO, 4);
    step(1, 1, 0, 1, 0, XSLR, 5);
    step(1, 1, 0, 1, 0, XSOP, 6);
    // ZP load, ZPI store
    step(1, 1, 2, 0, 0, XS0, 0);
    step(1, 1, 0, 1, 0, XSLO, 1);
    step(1, 1, 0, 1, 0, XSLR, 2);
    step(1, 1, 0, 1, 0, XSOP, 3);
    step(1, 1, 3, 1, 0, XS0, 0);
    step(1, 1, 0, 0, 0, XSLO, 1);
    step(1, 1, 0, 0, 0, XSIN, 2);
    step(1, 1, 0, 0, 0, XSOP, 3);
    // RDY=0 in S0 must not latch mode
    step(1, 0, 4, 0, 0, XS0, 0);
    step(1, 1, 0, 0, 0, XS0, 0);
    step(1, 1, 0, 0, 0, XSOP, 1);
    // reset during SCO
    step(1, 1, 5, 0, 0, XS0, 0);
    step(1, 1, 0, 0, 0, XSLO, 1);
    step(1, 1, 0, 0, 1, XSHI, 2);
    step(0, 0, 0, 0, 0, XSCO, 3);
    step(1, 1, 0, 0, 0, XS0, 0);
    step(1, 1, 0, 0, 0, XSOP, 1);
    step(1, 1, 7, 0, 0, XS0, 0);
`ifdef FSM_SEQ_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) stepj(1, 1'(i));
    rst_n = 1'b0; rdy = 1'b0;
    q.push_back('{s: XNON, jam: 1'b1, cyc: 3'd0, chk_cyc: 1'b0});
    @(posedge clk); #1;
    step(1, 1, 0, 0, 0, XS0, 0);
`else
    step(1, 1, 0, 0, 0, XSOP, 1);
    step(1, 1, 0, 0, 0, XS0, 0);
`endif
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
